// File: rtl/fifo_pkg.sv
// fifo_pkg: constants and types shared by the 8 x 32 synchronous FIFO and
// its read-side controller.
//   FIFO_DATA_W / FIFO_DEPTH / FIFO_CNT_W : FIFO geometry
//   occ_e       : skid-buffer occupancy encoding
//   occ_count() : occupancy state to word count
package fifo_pkg;

  localparam int FIFO_DATA_W = 32;
  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_CNT_W  = 4;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b10
  } occ_e;

  // Any illegal encoding counts as full, so a corrupted state stops further
  // reads rather than allowing an overflow.
  function automatic logic [1:0] occ_count(input occ_e o);
    case (o)
      OCC_EMPTY: occ_count = 2'd0;
      OCC_ONE:   occ_count = 2'd1;
      OCC_TWO:   occ_count = 2'd2;
      default:   occ_count = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_chk.sv
// fifo_rd_ctrl_chk: protocol checker for the FIFO read interface.
// Flags an rd_ack that was never requested and an inconsistent FIFO status
// (data_count of 0 while empty is low).
// Ports: clk, reset_n, empty, data_count, rd_ack, pend (controller's
// outstanding-request register).
module fifo_rd_ctrl_chk #(
  parameter int CNT_W = 4
) (
  input logic             clk,
  input logic             reset_n,
  input logic             empty,
  input logic [CNT_W-1:0] data_count,
  input logic             rd_ack,
  input logic             pend
);

  a_ack_without_request : assert property (
    @(posedge clk) disable iff (!reset_n) !(rd_ack && !pend));

  a_count_vs_empty : assert property (
    @(posedge clk) disable iff (!reset_n) !(!empty && (data_count == {CNT_W{1'b0}})));

endmodule

// File: rtl/fifo_rd_ctrl_skid_buf_2.sv
// fifo_rd_ctrl_skid_buf_2: two-entry skid buffer holding words returned by
// the FIFO until the downstream sink accepts them. Strict FIFO order; the
// head entry drives m_data directly.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   push, din        write din at the tail
//   pop              head consumed this cycle (only meaningful when m_valid)
//   occ              current occupancy state
//   m_valid, m_data  registered head word and its valid flag
module fifo_rd_ctrl_skid_buf_2
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output occ_e              occ,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data
);

  occ_e              occ_r;
  occ_e              occ_nxt_s;
  logic [DATA_W-1:0] head_r;
  logic [DATA_W-1:0] tail_r;
  logic [DATA_W-1:0] head_nxt_s;
  logic [DATA_W-1:0] tail_nxt_s;
  logic              valid_r;

  // Next-state selection for occupancy and the two data entries.
  always_comb begin
    occ_nxt_s  = occ_r;
    head_nxt_s = head_r;
    tail_nxt_s = tail_r;
    case ({push, pop})
      2'b10: begin
        case (occ_r)
          OCC_EMPTY: begin
            head_nxt_s = din;
            occ_nxt_s  = OCC_ONE;
          end
          OCC_ONE: begin
            tail_nxt_s = din;
            occ_nxt_s  = OCC_TWO;
          end
          // A push into a full buffer cannot be requested; hold state.
          default: occ_nxt_s = occ_r;
        endcase
      end
      2'b01: begin
        case (occ_r)
          OCC_ONE: occ_nxt_s = OCC_EMPTY;
          OCC_TWO: begin
            head_nxt_s = tail_r;
            occ_nxt_s  = OCC_ONE;
          end
          default: occ_nxt_s = occ_r;
        endcase
      end
      2'b11: begin
        case (occ_r)
          // pop with EMPTY cannot occur (m_valid gates it); treat as push.
          OCC_EMPTY: begin
            head_nxt_s = din;
            occ_nxt_s  = OCC_ONE;
          end
          OCC_ONE: head_nxt_s = din;
          OCC_TWO: begin
            head_nxt_s = tail_r;
            tail_nxt_s = din;
          end
          default: occ_nxt_s = occ_r;
        endcase
      end
      default: occ_nxt_s = occ_r;
    endcase
  end

  // Buffer state registers; m_valid is registered alongside occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_r   <= OCC_EMPTY;
      head_r  <= {DATA_W{1'b0}};
      tail_r  <= {DATA_W{1'b0}};
      valid_r <= 1'b0;
    end else begin
      occ_r   <= occ_nxt_s;
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      valid_r <= (occ_nxt_s != OCC_EMPTY);
    end
  end

  assign occ     = occ_r;
  assign m_valid = valid_r;
  assign m_data  = head_r;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller for the 8 x 32 synchronous FIFO.
// Issues rd_en, absorbs the FIFO's one-cycle read latency in a two-entry
// skid buffer and presents words on a valid/ready stream.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   empty, data_count   FIFO status (data_count is monitored only)
//   rd_ack, rd_err      FIFO read response, one cycle after rd_en
//   dout                FIFO read data, valid with rd_ack
//   rd_en               FIFO read request
//   m_valid, m_data     downstream stream (registered)
//   m_ready             downstream accept
//   err_cnt             saturating rd_err count, only when the macro
//                       FIFO_RD_CTRL_ERRCNT_EN is defined
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int CNT_W  = FIFO_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              empty,
  input  logic [CNT_W-1:0]  data_count,
  input  logic              rd_ack,
  input  logic              rd_err,
  input  logic [DATA_W-1:0] dout,
  output logic              rd_en,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready
`ifdef FIFO_RD_CTRL_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  occ_e       occ_s;
  logic       pend_r;
  logic       pop_s;
  logic       push_s;
  logic       rd_en_s;
  logic [2:0] inflight_s;
  logic [2:0] limit_s;
  logic       unused_s;

  assign pop_s  = m_valid & m_ready;
  // An acknowledge we did not request is dropped.
  assign push_s = rd_ack & pend_r;

  // Read request: words buffered plus in flight, less the one leaving now,
  // must stay below two. Gated by reset_n so it is 0 while in reset.
  always_comb begin
    inflight_s = {1'b0, occ_count(occ_s)} + {2'b00, pend_r};
    limit_s    = 3'd2 + {2'b00, pop_s};
    rd_en_s    = reset_n & ~empty & (inflight_s < limit_s);
  end

  assign rd_en = rd_en_s;

  // Outstanding-request flag: the FIFO answers exactly one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_r <= 1'b0;
    end else begin
      pend_r <= rd_en_s;
    end
  end

  fifo_rd_ctrl_skid_buf_2 #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .din     (dout),
    .pop     (pop_s),
    .occ     (occ_s),
    .m_valid (m_valid),
    .m_data  (m_data)
  );

`ifdef FIFO_RD_CTRL_ERRCNT_EN
  logic [7:0] err_cnt_r;

  // Saturating count of FIFO read errors.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_r <= 8'd0;
    end else if (rd_err && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`endif

  // data_count is observed only by the protocol checker; rd_err only by the
  // optional counter.
  assign unused_s = ^{data_count, rd_err};

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: self-checking bench for fifo_rd_ctrl. A behavioural FIFO
// with one-cycle read latency feeds the DUT; a queue of written words and
// request/delivery counters predict rd_en, m_valid and m_data each cycle.
module tb_fifo_rd_ctrl;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        empty;
  logic [3:0]  data_count;
  logic        rd_ack;
  logic        rd_err;
  logic [31:0] dout;
  logic        rd_en;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;
`ifdef FIFO_RD_CTRL_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  always #5 clk = ~clk;

  fifo_rd_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .empty      (empty),
    .data_count (data_count),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .dout       (dout),
    .rd_en      (rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready)
`ifdef FIFO_RD_CTRL_ERRCNT_EN
    ,.err_cnt   (err_cnt)
`endif
  );

  fifo_rd_ctrl_chk #(.CNT_W(4)) u_chk (
    .clk        (clk),
    .reset_n    (reset_n),
    .empty      (empty),
    .data_count (data_count),
    .rd_ack     (rd_ack),
    .pend       (dut.pend_r)
  );

  // Behavioural FIFO: circular store, one-cycle read latency.
  logic [31:0] mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        f_err;
  logic        force_err = 1'b0;

  assign empty      = (wr_ptr == rd_ptr);
  assign data_count = 4'(wr_ptr - rd_ptr);
  assign rd_err     = f_err | force_err;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ack <= 1'b0;
      f_err  <= 1'b0;
      dout   <= 32'd0;
    end else if (rd_en && (wr_ptr != rd_ptr)) begin
      dout   <= mem[rd_ptr % 64];
      rd_ack <= 1'b1;
      f_err  <= 1'b0;
      rd_ptr <= rd_ptr + 1;
    end else begin
      rd_ack <= 1'b0;
      f_err  <= rd_en;
    end
  end

  // Reference state
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  int          issued_before = 0;
  int          popped_before = 0;
  bit          last_rd = 1'b0;

  typedef struct {
    bit rdy;
    bit en;
    bit vld;
    int didx;
  } vec_t;

  vec_t        tbl[11];
  logic [31:0] words[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load(input logic [31:0] w);
    mem[wr_ptr % 64] = w;
    exp_q.push_back(w);
    wr_ptr++;
  endtask

  // Assert reset, empty the FIFO and the reference model, hold two cycles.
  task automatic hold_reset();
    reset_n = 1'b0;
    #1;
    wr_ptr        = rd_ptr;
    exp_q.delete();
    issued_before = 0;
    popped_before = 0;
    last_rd       = 1'b0;
    m_ready       = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_rst_outputs(input string tag);
    chk({tag, "_rd_en"},   32'(rd_en),   32'd0);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_data"},  m_data,       32'd0);
`ifdef FIFO_RD_CTRL_ERRCNT_EN
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
`endif
  endtask

  // One clock cycle: optionally release reset, push npush random words into
  // the FIFO, drive m_ready, then compare against the reference model.
  task automatic cycle(input bit rdy, input int npush, input bit rel);
    bit          ev;
    bit          pop;
    bit          er;
    logic [31:0] w;
    @(negedge clk);
    if (rel) reset_n = 1'b1;
    for (int k = 0; k < npush; k++) begin
      w = $urandom;
      load(w);
    end
    m_ready = rdy;
    #1;
    // A word requested at cycle t is visible from t+2.
    ev = (issued_before - int'(last_rd) - popped_before) > 0;
    chk("m_valid", 32'(m_valid), 32'(ev));
    pop = ev && rdy;
    if (pop) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL m_data: word delivered %h, expected none", m_data);
      end else begin
        chk("m_data", m_data, exp_q.pop_front());
      end
    end
    er = (wr_ptr != rd_ptr) && ((issued_before - popped_before - int'(pop)) < 2);
    chk("rd_en", 32'(rd_en), 32'(er));
    if (!force_err) chk("rd_err", 32'(rd_err), 32'd0);
    issued_before += int'(er);
    popped_before += int'(pop);
    last_rd        = er;
  endtask

  task automatic reset_midop(input int stall);
    hold_reset();
    for (int i = 0; i < 6; i++) load(32'hDEAD_0000 + 32'(i));
    cycle(1'b0, 0, 1'b1);
    for (int i = 1; i < stall; i++) cycle(1'b0, 0, 1'b0);
    reset_n = 1'b0;
    #1;
    check_rst_outputs("async_rst");
    hold_reset();
    load(32'h5A5A_0001);
    load(32'h5A5A_0002);
    cycle(1'b1, 0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 0, 1'b0);
    chk("midop_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    words[0] = 32'hA000_0001;
    words[1] = 32'hA000_0002;
    words[2] = 32'hA000_0003;
    words[3] = 32'hA000_0004;
    words[4] = 32'hA000_0005;
    // 5 words with a stalled sink, then released: {m_ready, rd_en, m_valid, head}
    tbl[0]  = '{1'b0, 1'b1, 1'b0, -1};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, -1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1,  0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1,  0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1,  0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1,  0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1,  1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1,  2};
    tbl[8]  = '{1'b1, 1'b0, 1'b1,  3};
    tbl[9]  = '{1'b1, 1'b0, 1'b1,  4};
    tbl[10] = '{1'b1, 1'b0, 1'b0, -1};

    reset_n = 1'b1;
    m_ready = 1'b0;
    #2;

    // Reset with 3 words waiting; m_valid rises at cycle 2 after release.
    hold_reset();
    load(32'h0000_0101);
    load(32'h0000_0202);
    load(32'h0000_0303);
    @(negedge clk);
    check_rst_outputs("reset");
    cycle(1'b1, 0, 1'b1);
    cycle(1'b1, 0, 1'b0);
    cycle(1'b1, 0, 1'b0);
    chk("first_valid_c2", 32'(m_valid), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 0, 1'b0);
    chk("reset_drain_left", 32'(exp_q.size()), 32'd0);

    // Table-driven stall/release.
    hold_reset();
    for (int i = 0; i < 5; i++) load(words[i]);
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].rdy, 0, i == 0);
      chk($sformatf("tbl%0d_rd_en", i),   32'(rd_en),   32'(tbl[i].en));
      chk($sformatf("tbl%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].vld));
      if (tbl[i].didx >= 0) chk($sformatf("tbl%0d_m_data", i), m_data, words[tbl[i].didx]);
    end

    // Preloaded 0x11..0x88 with the sink always ready: 8 consecutive words.
    hold_reset();
    for (int i = 1; i <= 8; i++) load(32'h11 * 32'(i));
    for (int c = 0; c < 12; c++) begin
      cycle(1'b1, 0, c == 0);
      if (c >= 2 && c <= 9) begin
        chk($sformatf("burst_c%0d_valid", c), 32'(m_valid), 32'd1);
        chk($sformatf("burst_c%0d_data", c),  m_data,       32'h11 * 32'(c - 1));
      end
    end
    chk("burst_left", 32'(exp_q.size()), 32'd0);

    // m_ready toggling every cycle.
    hold_reset();
    for (int i = 0; i < 8; i++) load(32'hC0DE_0000 + 32'(i));
    for (int c = 0; c < 30; c++) cycle((c % 2) == 0, 0, c == 0);
    chk("toggle_left", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with a word in flight, and with the buffer full.
    reset_midop(3);
    reset_midop(4);

    // Random traffic.
    hold_reset();
    cycle(1'b1, 0, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(0, 3) != 0,
            ((wr_ptr - rd_ptr) < 8 && $urandom_range(0, 2) != 0) ? 1 : 0, 1'b0);
    end
    for (int c = 0; c < 12; c++) cycle(1'b1, 0, 1'b0);
    chk("random_left", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_RD_CTRL_ERRCNT_EN
    // rd_err held high for 300 cycles saturates the counter at 255.
    hold_reset();
    check_rst_outputs("errcnt_reset");
    cycle(1'b1, 0, 1'b1);
    force_err = 1'b1;
    for (int c = 0; c < 300; c++) cycle(1'b1, 0, 1'b0);
    force_err = 1'b0;
    cycle(1'b1, 0, 1'b0);
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
    chk("err_m_valid", 32'(m_valid), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
